alu_arbiter: RTL and testbench

Shares the CPU's single 32-bit `alu` between `NREQ` independent requesters (e.g. address-generation unit and a debug/test port). Each requester issues one operation through a valid/ready handshake and receives its result through a per-requester valid/ready response. A round-robin grant keeps service fair. One operation is in flight at a time; operands and result are registered around the shared ALU instance.

---
 rtl/alu_arb_pkg.sv | 25 ++
 rtl/alu.sv | 38 +++
 rtl/alu_rr_grant.sv | 36 +++
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: ALUControl codes, FSM states and
// the opcode legality helper.
package alu_arb_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // True for the five ALUControl codes the ALU is defined for.
  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU. alucontrol[2] inverts B and injects a
// carry (subtract); alucontrol[1:0] selects AND, OR, SUM or set-less-than.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic [WIDTH-1:0]        b_mux;
  logic [WIDTH-1:0]        sum;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    slt;

  assign b_mux = alucontrol[2] ? ~b : b;
  assign sum   = a + b_mux + {{(WIDTH-1){1'b0}}, alucontrol[2]};
  assign a_s   = a;
  assign b_s   = b;
  assign slt   = (a_s < b_s);

  // Result select on the low two control bits.
  always_comb begin
    result = '0;
    case (alucontrol[1:0])
      2'b00:   result = a & b_mux;
      2'b01:   result = a | b_mux;
      2'b10:   result = sum;
      default: result = {{(WIDTH-1){1'b0}}, slt};
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_rr_grant.sv
// Combinational round-robin priority encoder: picks the first valid
// requester at or after the priority pointer, wrapping modulo NREQ.
module alu_rr_grant #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  logic [IDXW:0] cand;
  logic          found;

  // Scan NREQ candidates starting at the pointer; the first valid one wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (IDXW+1)'(i);
      if (cand >= (IDXW+1)'(NREQ)) cand = cand - (IDXW+1)'(NREQ);
      if (!found && valid[cand[IDXW-1:0]]) begin
        found                   = 1'b1;
        grant[cand[IDXW-1:0]]   = 1'b1;
        idx                     = cand[IDXW-1:0];
      end
    end
  end

  assign any = |valid;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters with round-robin arbitration.
// One operation in flight: IDLE (arbitrate/accept) -> EXEC (ALU on latched
// operands, result registered) -> RESP (hold response until consumed).
// Optional macro ALU_ARB_OPCHECK_EN: illegal opcodes (011/100/101) return
// result 0, zero 1, err 1; without it rsp_err is tied low.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0] req_a,
  input  logic [NREQ-1:0][WIDTH-1:0] req_b,
  input  logic [NREQ-1:0][2:0]       req_op,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [WIDTH-1:0]           rsp_result,
  output logic                       rsp_zero,
  output logic                       rsp_err
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state;
  state_t            state_nx;
  logic [IDXW-1:0]   ptr;
  logic [NREQ-1:0]   grant;
  logic [IDXW-1:0]   gidx;
  logic              any_valid;
  logic              accept;

  logic [WIDTH-1:0]  a_p0;
  logic [WIDTH-1:0]  b_p0;
  logic [2:0]        op_p0;
  logic [IDXW-1:0]   id_p0;

  logic [WIDTH-1:0]  alu_result;
  logic              alu_zero;
  logic [WIDTH-1:0]  result_p1;
  logic              zero_p1;

  alu_rr_grant #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_grant (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any_valid)
  );

  assign accept    = (state == IDLE) && any_valid;
  assign req_ready = (accept && reset_n) ? grant : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic; the response waits only on the granted requester.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_valid)         state_nx = EXEC;
      EXEC:                           state_nx = RESP;
      RESP:    if (rsp_ready[id_p0])  state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  // Pointer and owner id advance on acceptance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr   <= '0;
      id_p0 <= '0;
    end else if (accept) begin
      id_p0 <= gidx;
      ptr   <= (gidx == IDXW'(NREQ-1)) ? '0 : gidx + IDXW'(1);
    end
  end

  // Stage p0: operand latch at the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0  <= req_a[gidx];
      b_p0  <= req_b[gidx];
      op_p0 <= req_op[gidx];
    end
  end

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a          (a_p0),
    .b          (b_p0),
    .alucontrol (op_p0),
    .result     (alu_result),
    .zero       (alu_zero)
  );

`ifdef ALU_ARB_OPCHECK_EN
  logic illegal;
  logic err_p1;

  assign illegal = !op_legal(op_p0);

  // Stage p1: result register, illegal opcodes squashed to zero with err.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result_p1 <= '0;
      zero_p1   <= 1'b0;
      err_p1    <= 1'b0;
    end else if (state == EXEC) begin
      result_p1 <= illegal ? '0   : alu_result;
      zero_p1   <= illegal ? 1'b1 : alu_zero;
      err_p1    <= illegal;
    end
  end

  assign rsp_err = err_p1;
`else
  // Stage p1: result register, ALU output taken as-is.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result_p1 <= '0;
      zero_p1   <= 1'b0;
    end else if (state == EXEC) begin
      result_p1 <= alu_result;
      zero_p1   <= alu_zero;
    end
  end

  assign rsp_err = 1'b0;
`endif

  // Response valid goes only to the owner of the in-flight operation.
  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[id_p0] = 1'b1;
  end

  assign rsp_result = result_p1;
  assign rsp_zero   = zero_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, hand sequences for backpressure,
// reset-in-flight and rotation, then randomized traffic against a
// transaction-level reference model.
module tb_alu_arbiter;

  localparam int NREQ  = 3;
  localparam int WIDTH = 32;
  localparam int IW    = 2;

  typedef logic [IW-1:0] idx_t;

  typedef struct {
    idx_t        id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  logic                       clk = 1'b0;
  logic                       reset_n;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][WIDTH-1:0] req_a;
  logic [NREQ-1:0][WIDTH-1:0] req_b;
  logic [NREQ-1:0][2:0]       req_op;
  logic [NREQ-1:0]            rsp_valid;
  logic [NREQ-1:0]            rsp_ready;
  logic [WIDTH-1:0]           rsp_result;
  logic                       rsp_zero;
  logic                       rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input idx_t i);
    logic [NREQ-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // Reference ALU semantics written from the opcode definitions.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // First valid requester at or after pointer p, modulo NREQ.
  function automatic idx_t exp_grant(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (p + k) % NREQ;
      if (v[idx_t'(c)]) return idx_t'(c);
    end
    return idx_t'(0);
  endfunction

  task automatic new_operands(input idx_t r);
    logic [2:0] ops [5];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b110; ops[4] = 3'b111;
    req_op[r] = ops[$urandom_range(4)];
    req_a[r]  = ($urandom_range(1) == 0) ? $urandom : 32'($urandom_range(16));
    req_b[r]  = ($urandom_range(1) == 0) ? $urandom : 32'($urandom_range(16));
  endtask

  // Reset with all requests asserted; nothing may be accepted or responded.
  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '1;
    rsp_ready = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;
    reset_n   = 1'b1;
    req_valid = '0;
  endtask

  // One transaction from a lone requester, starting and ending with the
  // arbiter idle; called at posedge+1.
  task automatic do_op(input idx_t id, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res,
                       output logic zero, output logic err);
    int lat;
    bit seen;
    req_a[id]     = a;
    req_b[id]     = b;
    req_op[id]    = op;
    req_valid[id] = 1'b1;
    @(negedge clk);
    chk("op_accept_ready", 32'(req_ready), 32'(onehot(id)));
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 8) begin
      @(negedge clk);
      lat++;
      if (rsp_valid != '0) seen = 1'b1;
    end
    res  = rsp_result;
    zero = rsp_zero;
    err  = rsp_err;
    if (!seen) begin
      chk("op_rsp_timeout", 32'd0, 32'd1);
    end else begin
      chk("op_latency", 32'(lat), 32'd2);
      chk("op_rsp_valid", 32'(rsp_valid), 32'(onehot(id)));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [12];
    logic [31:0] res;
    logic        zero;
    logic        err;
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] exp_rv;
    logic [NREQ-1:0] acc_mask;
    bit          busy;
    bit          was_busy;
    bit          seen;
    idx_t        g;
    idx_t        b_id;
    logic [31:0] b_res;
    int          b_acc;
    int          ptr_m;
    int          cyc;
    int          accepts;
    int          n;

    tbl[0]  = '{id: 2'd0, op: 3'b010, a: 32'd5,          b: 32'd10,         res: 32'd15,         zero: 1'b0};
    tbl[1]  = '{id: 2'd1, op: 3'b110, a: 32'd5,          b: 32'd10,         res: 32'hFFFF_FFFB,  zero: 1'b0};
    tbl[2]  = '{id: 2'd2, op: 3'b000, a: 32'd5,          b: 32'd10,         res: 32'd0,          zero: 1'b1};
    tbl[3]  = '{id: 2'd0, op: 3'b111, a: 32'd5,          b: 32'd10,         res: 32'd1,          zero: 1'b0};
    tbl[4]  = '{id: 2'd0, op: 3'b001, a: 32'd25,         b: 32'hFFFF_FFF1,  res: 32'hFFFF_FFF9,  zero: 1'b0};
    tbl[5]  = '{id: 2'd1, op: 3'b010, a: 32'hFFFF_FFFF,  b: 32'd1,          res: 32'd0,          zero: 1'b1};
    tbl[6]  = '{id: 2'd2, op: 3'b010, a: 32'h7FFF_FFFF,  b: 32'd1,          res: 32'h8000_0000,  zero: 1'b0};
    tbl[7]  = '{id: 2'd1, op: 3'b110, a: 32'h8000_0000,  b: 32'd1,          res: 32'h7FFF_FFFF,  zero: 1'b0};
    tbl[8]  = '{id: 2'd2, op: 3'b111, a: 32'd10,         b: 32'd5,          res: 32'd0,          zero: 1'b1};
    tbl[9]  = '{id: 2'd0, op: 3'b111, a: 32'hFFFF_FFFF,  b: 32'd1,          res: 32'd1,          zero: 1'b0};
    tbl[10] = '{id: 2'd1, op: 3'b110, a: 32'd77,         b: 32'd77,         res: 32'd0,          zero: 1'b1};
    tbl[11] = '{id: 2'd2, op: 3'b001, a: 32'hA5A5_0000,  b: 32'h0000_5A5A,  res: 32'hA5A5_5A5A,  zero: 1'b0};

    req_valid = '0;
    rsp_ready = '1;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    reset_n   = 1'b0;
    do_reset();

    // Vector table, one isolated transaction per entry.
    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b, res, zero, err);
      chk($sformatf("vec%0d_result", i), res, tbl[i].res);
      chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(tbl[i].zero));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'd0);
    end

    // Backpressure on requester 1 while requester 0 waits.
    rsp_ready = 3'b101;
    req_a[1] = 32'd5; req_b[1] = 32'd10; req_op[1] = 3'b000;
    req_valid = 3'b010;
    @(negedge clk);
    chk("bp_grant1", 32'(req_ready), 32'b010);
    @(posedge clk); #1;
    req_valid = 3'b001;
    req_a[0] = 32'd1; req_b[0] = 32'd2; req_op[0] = 3'b010;
    @(negedge clk);
    chk("bp_exec_ready", 32'(req_ready), 32'd0);
    chk("bp_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 32'b010);
      chk("bp_hold_result", rsp_result, 32'd0);
      chk("bp_hold_zero", 32'(rsp_zero), 32'd1);
      chk("bp_hold_ready0", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = '1;
    @(negedge clk);
    chk("bp_release_valid", 32'(rsp_valid), 32'b010);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_next_grant0", 32'(req_ready), 32'b001);
    @(posedge clk); #1;
    req_valid = '0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      if (rsp_valid != '0) seen = 1'b1;
    end
    chk("bp_req0_seen", 32'(seen), 32'd1);
    chk("bp_req0_valid", 32'(rsp_valid), 32'b001);
    chk("bp_req0_result", rsp_result, 32'd3);
    @(posedge clk); #1;

    // Out-of-table opcode.
    do_op(2'd0, 3'b100, 32'd5, 32'd10, res, zero, err);
`ifdef ALU_ARB_OPCHECK_EN
    chk("illegal_result", res, 32'd0);
    chk("illegal_zero", 32'(zero), 32'd1);
    chk("illegal_err", 32'(err), 32'd1);
`else
    chk("illegal_err", 32'(err), 32'd0);
`endif

    // Reset during EXEC drops the operation and returns the pointer to 0.
    req_a[0] = 32'd7; req_b[0] = 32'd8; req_op[0] = 3'b010;
    req_valid = 3'b001;
    @(negedge clk);
    chk("rst_exec_grant", 32'(req_ready), 32'b001);
    @(posedge clk); #1;
    req_valid = '0;
    reset_n   = 1'b0;
    @(posedge clk); #1;
    reset_n   = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_exec_no_rsp", 32'(rsp_valid), 32'd0);
      chk("rst_exec_result", rsp_result, 32'd0);
    end
    @(posedge clk); #1;

    // Two persistent requesters: strict alternation from requester 0.
    for (int r = 0; r < 2; r++) begin
      req_a[r] = 32'd5; req_b[r] = 32'd10; req_op[r] = 3'b110;
    end
    req_valid = 3'b011;
    for (int k = 0; k < 4; k++) begin
      idx_t want;
      want = idx_t'(k % 2);
      seen = 1'b0;
      n = 0;
      while (!seen && n < 8) begin
        @(negedge clk);
        n++;
        if (req_ready != '0) seen = 1'b1;
      end
      chk($sformatf("alt%0d_grant", k), 32'(req_ready), 32'(onehot(want)));
      seen = 1'b0;
      n = 0;
      while (!seen && n < 8) begin
        @(negedge clk);
        n++;
        if (rsp_valid != '0) seen = 1'b1;
      end
      chk($sformatf("alt%0d_rsp_valid", k), 32'(rsp_valid), 32'(onehot(want)));
      chk($sformatf("alt%0d_result", k), rsp_result, 32'hFFFF_FFFB);
      chk($sformatf("alt%0d_zero", k), 32'(rsp_zero), 32'd0);
    end
    @(posedge clk); #1;
    req_valid = '0;

    // Randomized traffic against the transaction-level model.
    do_reset();
    busy    = 1'b0;
    ptr_m   = 0;
    cyc     = 0;
    accepts = 0;
    b_id    = '0;
    b_res   = '0;
    b_acc   = 0;
    for (int t = 0; t < 800; t++) begin
      @(negedge clk);
      cyc++;
      was_busy = busy;
      g        = '0;
      exp_rdy  = '0;
      if (!was_busy && req_valid != '0) begin
        g       = exp_grant(req_valid, ptr_m);
        exp_rdy = onehot(g);
      end
      chk("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));

      exp_rv = '0;
      if (was_busy && cyc >= b_acc + 2) begin
        exp_rv = onehot(b_id);
        chk("rnd_result", rsp_result, b_res);
        chk("rnd_zero", 32'(rsp_zero), 32'(b_res == 32'd0));
        chk("rnd_err", 32'(rsp_err), 32'd0);
        if (rsp_ready[b_id]) busy = 1'b0;
      end
      chk("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rv));

      acc_mask = '0;
      if (!was_busy && req_valid != '0) begin
        busy     = 1'b1;
        b_id     = g;
        b_res    = ref_alu(req_op[g], req_a[g], req_b[g]);
        b_acc    = cyc;
        ptr_m    = (int'(g) + 1) % NREQ;
        acc_mask = onehot(g);
        accepts++;
      end

      @(posedge clk); #1;
      for (int r = 0; r < NREQ; r++) begin
        idx_t ri;
        ri = idx_t'(r);
        if (acc_mask[ri]) begin
          req_valid[ri] = ($urandom_range(3) != 0);
          new_operands(ri);
        end else if (req_valid[ri]) begin
          if ($urandom_range(15) == 0) req_valid[ri] = 1'b0;
        end else if ($urandom_range(1) == 0) begin
          req_valid[ri] = 1'b1;
          new_operands(ri);
        end
        rsp_ready[ri] = ($urandom_range(2) != 0);
      end
    end
    chk("rnd_enough_accepts", 32'(accepts > 50), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
